// File: rtl/sector_sched_ctrl.sv
// Sector scheduling controller: a single phase counter drives a fixed-slot
// arbiter that updates the IS/ISS/DS/DSS sector registers.
// Once per computer cycle it also produces a one-hot Y-address sector select.
// Legal configuration: 4 <= PHASES <= 16, ARB_SLOT != DEC_SLOT, and both slots < PHASES.
module sector_sched_ctrl #(
   parameter int PHASES   = 8,
   parameter int ARB_SLOT = 3,
   parameter int DEC_SLOT = 6
) (
   input  logic                      CLK,
   input  logic                      RSTN,
   input  logic                      HOP_REQ,
   input  logic [9:0]                HOP_DATA,
   input  logic                      CDS_REQ,
   input  logic [4:0]                CDS_DATA,
   input  logic                      TRA_REQ,
   input  logic [3:0]                TRA_DATA,
   input  logic                      PAD_IN,
   input  logic                      A9_IN,
   output logic                      HOP_ACK,
   output logic                      CDS_ACK,
   output logic                      TRA_ACK,
   output logic [3:0]                IS,
   output logic                      ISS,
   output logic [3:0]                DS,
   output logic                      DSS,
   output logic [$clog2(PHASES)-1:0] PHASE,
   output logic [7:0]                SEL_Y,
   output logic                      SEL_HI,
   output logic                      SEL_VALID
);

   localparam int PH_W = $clog2(PHASES);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
   localparam logic [PH_W-1:0] ARB_PH  = PH_W'(ARB_SLOT);
   localparam logic [PH_W-1:0] DEC_PH  = PH_W'(DEC_SLOT);

   // Residual sector used when the operand address has bit 9 set.
   localparam logic [3:0] RESIDUAL_SRC = 4'b0111;

   logic [PH_W-1:0] phase_q, phase_d;
   logic [3:0]      is_q, is_d;
   logic            iss_q, iss_d;
   logic [3:0]      ds_q, ds_d;
   logic            dss_q, dss_d;
   logic            hop_ack_q, hop_ack_d;
   logic            cds_ack_q, cds_ack_d;
   logic            tra_ack_q, tra_ack_d;
   logic [7:0]      sel_y_q, sel_y_d;
   logic            sel_hi_q, sel_hi_d;
   logic            sel_valid_q, sel_valid_d;

   logic            arb_edge_s;
   logic            dec_edge_s;
   logic            hop_gnt_s;
   logic            cds_gnt_s;
   logic            tra_gnt_s;
   logic [3:0]      src_s;

   // One-hot Y select from a 3-bit sector index; never multi-hot.
   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

   // Next-state logic: phase counter, fixed-slot arbitration, register loads and sector decode.
   always_comb begin
      phase_d     = phase_q;
      is_d        = is_q;
      iss_d       = iss_q;
      ds_d        = ds_q;
      dss_d       = dss_q;
      hop_ack_d   = 1'b0;
      cds_ack_d   = 1'b0;
      tra_ack_d   = 1'b0;
      sel_y_d     = sel_y_q;
      sel_hi_d    = sel_hi_q;
      sel_valid_d = 1'b0;
      src_s       = ds_q;

      if (phase_q == PH_LAST) begin
         phase_d = {PH_W{1'b0}};
      end else begin
         phase_d = phase_q + PH_W'(1);
      end

      arb_edge_s = (phase_q == ARB_PH);
      dec_edge_s = (phase_q == DEC_PH);

      // HOP wins the slot outright; TRA and CDS touch disjoint fields and may share it.
      hop_gnt_s = arb_edge_s & HOP_REQ;
      tra_gnt_s = arb_edge_s & ~HOP_REQ & TRA_REQ;
      cds_gnt_s = arb_edge_s & ~HOP_REQ & CDS_REQ;

      hop_ack_d = hop_gnt_s;
      tra_ack_d = tra_gnt_s;
      cds_ack_d = cds_gnt_s;

      if (hop_gnt_s) begin
         is_d  = HOP_DATA[9:6];
         iss_d = HOP_DATA[5];
         ds_d  = HOP_DATA[4:1];
         dss_d = HOP_DATA[0];
      end else begin
         if (tra_gnt_s) begin
            is_d = TRA_DATA;
         end else begin
            is_d = is_q;
         end
         if (cds_gnt_s) begin
            ds_d  = CDS_DATA[4:1];
            dss_d = CDS_DATA[0];
         end else begin
            ds_d  = ds_q;
            dss_d = dss_q;
         end
      end

      // Source selection uses the registers as they stand before the decode edge.
      if (PAD_IN) begin
         src_s = is_q;
      end else if (A9_IN) begin
         src_s = RESIDUAL_SRC;
      end else begin
         src_s = ds_q;
      end

      if (dec_edge_s) begin
         sel_y_d     = onehot8(src_s[2:0]);
         sel_hi_d    = src_s[3];
         sel_valid_d = 1'b1;
      end else begin
         sel_y_d     = sel_y_q;
         sel_hi_d    = sel_hi_q;
         sel_valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset; reset discards any pending grant or decode.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         phase_q     <= {PH_W{1'b0}};
         is_q        <= 4'b0000;
         iss_q       <= 1'b0;
         ds_q        <= 4'b0000;
         dss_q       <= 1'b0;
         hop_ack_q   <= 1'b0;
         cds_ack_q   <= 1'b0;
         tra_ack_q   <= 1'b0;
         sel_y_q     <= 8'h00;
         sel_hi_q    <= 1'b0;
         sel_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         is_q        <= is_d;
         iss_q       <= iss_d;
         ds_q        <= ds_d;
         dss_q       <= dss_d;
         hop_ack_q   <= hop_ack_d;
         cds_ack_q   <= cds_ack_d;
         tra_ack_q   <= tra_ack_d;
         sel_y_q     <= sel_y_d;
         sel_hi_q    <= sel_hi_d;
         sel_valid_q <= sel_valid_d;
      end
   end

   assign PHASE     = phase_q;
   assign IS        = is_q;
   assign ISS       = iss_q;
   assign DS        = ds_q;
   assign DSS       = dss_q;
   assign HOP_ACK   = hop_ack_q;
   assign CDS_ACK   = cds_ack_q;
   assign TRA_ACK   = tra_ack_q;
   assign SEL_Y     = sel_y_q;
   assign SEL_HI    = sel_hi_q;
   assign SEL_VALID = sel_valid_q;

endmodule

// File: tb/tb_sector_sched_ctrl.sv
// Self-checking bench for sector_sched_ctrl: default configuration driven
// through a scoreboard of grant/decode events, plus a PHASES=4 corner instance.
module tb_sector_sched_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default-configuration instance signals
   logic       rstn;
   logic       hop_req, cds_req, tra_req, pad_in, a9_in;
   logic [9:0] hop_data;
   logic [4:0] cds_data;
   logic [3:0] tra_data;
   logic       hop_ack, cds_ack, tra_ack;
   logic [3:0] sec_is, sec_ds;
   logic       sec_iss, sec_dss;
   logic [2:0] phase;
   logic [7:0] sel_y;
   logic       sel_hi, sel_valid;

   // Corner instance signals (PHASES=4, ARB_SLOT=3, DEC_SLOT=0)
   logic       c_hop_req, c_cds_req, c_tra_req;
   logic [9:0] c_hop_data;
   logic [4:0] c_cds_data;
   logic [3:0] c_tra_data;
   logic       c_hop_ack, c_cds_ack, c_tra_ack;
   logic [3:0] c_is, c_ds;
   logic       c_iss, c_dss;
   logic [1:0] c_phase;
   logic [7:0] c_sel_y;
   logic       c_sel_hi, c_sel_valid;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] ack_exp_q[$];
   logic [31:0] ack_obs_q[$];
   logic [31:0] sel_exp_q[$];
   logic [31:0] sel_obs_q[$];

   sector_sched_ctrl u_dut (
      .CLK(clk), .RSTN(rstn),
      .HOP_REQ(hop_req), .HOP_DATA(hop_data),
      .CDS_REQ(cds_req), .CDS_DATA(cds_data),
      .TRA_REQ(tra_req), .TRA_DATA(tra_data),
      .PAD_IN(pad_in), .A9_IN(a9_in),
      .HOP_ACK(hop_ack), .CDS_ACK(cds_ack), .TRA_ACK(tra_ack),
      .IS(sec_is), .ISS(sec_iss), .DS(sec_ds), .DSS(sec_dss),
      .PHASE(phase), .SEL_Y(sel_y), .SEL_HI(sel_hi), .SEL_VALID(sel_valid)
   );

   sector_sched_ctrl #(.PHASES(4), .ARB_SLOT(3), .DEC_SLOT(0)) u_corner (
      .CLK(clk), .RSTN(rstn),
      .HOP_REQ(c_hop_req), .HOP_DATA(c_hop_data),
      .CDS_REQ(c_cds_req), .CDS_DATA(c_cds_data),
      .TRA_REQ(c_tra_req), .TRA_DATA(c_tra_data),
      .PAD_IN(1'b0), .A9_IN(1'b0),
      .HOP_ACK(c_hop_ack), .CDS_ACK(c_cds_ack), .TRA_ACK(c_tra_ack),
      .IS(c_is), .ISS(c_iss), .DS(c_ds), .DSS(c_dss),
      .PHASE(c_phase), .SEL_Y(c_sel_y), .SEL_HI(c_sel_hi), .SEL_VALID(c_sel_valid)
   );

   function automatic logic [31:0] ack_word(input logic h, input logic c, input logic t,
                                            input logic [3:0] ph, input logic [9:0] regs);
      return {1'b1, 4'd0, h, c, t, 4'd0, ph, 6'd0, regs};
   endfunction

   function automatic logic [31:0] sel_word(input logic [3:0] ph, input logic hi, input logic [7:0] y);
      return {1'b1, 18'd0, ph, hi, y};
   endfunction

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Event monitor: records every grant pulse and every decode pulse of the default instance.
   always @(negedge clk) begin
      if (hop_ack || cds_ack || tra_ack)
         ack_obs_q.push_back(ack_word(hop_ack, cds_ack, tra_ack, {1'b0, phase},
                                      {sec_is, sec_iss, sec_ds, sec_dss}));
      if (sel_valid)
         sel_obs_q.push_back(sel_word({1'b0, phase}, sel_hi, sel_y));
   end

   task automatic sb_flush();
      ack_obs_q.delete();
      sel_obs_q.delete();
   endtask

   task automatic sb_drain(input string tag);
      logic [31:0] e;
      logic [31:0] o;
      while (ack_exp_q.size() > 0) begin
         e = ack_exp_q.pop_front();
         if (ack_obs_q.size() > 0) o = ack_obs_q.pop_front();
         else o = 32'd0;
         check_value({tag, "_ack"}, o, e);
      end
      while (ack_obs_q.size() > 0) begin
         o = ack_obs_q.pop_front();
         check_value({tag, "_ack_extra"}, o, 32'd0);
      end
      while (sel_exp_q.size() > 0) begin
         e = sel_exp_q.pop_front();
         if (sel_obs_q.size() > 0) o = sel_obs_q.pop_front();
         else o = 32'd0;
         check_value({tag, "_sel"}, o, e);
      end
      while (sel_obs_q.size() > 0) begin
         o = sel_obs_q.pop_front();
         check_value({tag, "_sel_extra"}, o, 32'd0);
      end
   endtask

   task automatic wait_phase(input logic [2:0] p);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 64 && !hit; k++) begin
         @(negedge clk);
         if (phase == p) hit = 1'b1;
      end
      if (!hit) check_value("wait_phase_timeout", {29'd0, phase}, {29'd0, p});
   endtask

   // One computer cycle from phase 0 to the next phase 0 with the given stimulus held.
   task automatic run_cycle(input logic h, input logic [9:0] hd, input logic c, input logic [4:0] cd,
                            input logic t, input logic [3:0] td, input logic pad, input logic a9);
      sb_flush();
      hop_req = h; hop_data = hd;
      cds_req = c; cds_data = cd;
      tra_req = t; tra_data = td;
      pad_in = pad; a9_in = a9;
      wait_phase(3'd0);
      hop_req = 1'b0; cds_req = 1'b0; tra_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0;
      hop_req = 1'b0; cds_req = 1'b0; tra_req = 1'b0;
      hop_data = 10'd0; cds_data = 5'd0; tra_data = 4'd0;
      pad_in = 1'b0; a9_in = 1'b0;
      c_hop_req = 1'b0; c_cds_req = 1'b0; c_tra_req = 1'b0;
      c_hop_data = 10'd0; c_cds_data = 5'd0; c_tra_data = 4'd0;

      // Reset state and phase sequence
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("rst_phase", {29'd0, phase}, 32'd0);
      check_value("rst_regs", {22'd0, sec_is, sec_iss, sec_ds, sec_dss}, 32'd0);
      check_value("rst_acks", {29'd0, hop_ack, cds_ack, tra_ack}, 32'd0);
      check_value("rst_sel", {22'd0, sel_y, sel_hi, sel_valid}, 32'd0);
      check_value("rst_c_phase", {30'd0, c_phase}, 32'd0);
      rstn = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check_value("phase_seq", {29'd0, phase}, i % 8);
      end

      // HOP load: all ten bits, ack only at phase 4
      ack_exp_q.push_back(ack_word(1'b1, 1'b0, 1'b0, 4'd4, 10'b1011_1_0110_1));
      sel_exp_q.push_back(sel_word(4'd7, 1'b0, 8'b0100_0000));
      run_cycle(1'b1, 10'b1011_1_0110_1, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      sb_drain("hop_load");

      // TRA and CDS granted together; ISS untouched
      ack_exp_q.push_back(ack_word(1'b0, 1'b1, 1'b1, 4'd4, {4'b0101, 1'b1, 4'b0011, 1'b0}));
      sel_exp_q.push_back(sel_word(4'd7, 1'b0, 8'b0000_1000));
      run_cycle(1'b0, 10'd0, 1'b1, 5'b0011_0, 1'b1, 4'b0101, 1'b0, 1'b0);
      sb_drain("tra_cds");

      // HOP priority over TRA/CDS; decode from IS with PAD_IN=1
      ack_exp_q.push_back(ack_word(1'b1, 1'b0, 1'b0, 4'd4, 10'b0110_0_1010_0));
      sel_exp_q.push_back(sel_word(4'd7, 1'b0, 8'b0100_0000));
      run_cycle(1'b1, 10'b0110_0_1010_0, 1'b1, 5'b11111, 1'b1, 4'b1111, 1'b1, 1'b0);
      sb_drain("hop_prio");

      // Decode from DS (1010): index 2, sector bit 3 set
      sel_exp_q.push_back(sel_word(4'd7, 1'b1, 8'b0000_0100));
      run_cycle(1'b0, 10'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      sb_drain("dec_ds");

      // Residual sector
      sel_exp_q.push_back(sel_word(4'd7, 1'b0, 8'h80));
      run_cycle(1'b0, 10'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1);
      sb_drain("dec_res");

      // Short TRA request dropped before the slot, CDS pulsed off-slot
      sb_flush();
      a9_in = 1'b0;
      pad_in = 1'b0;
      sel_exp_q.push_back(sel_word(4'd7, 1'b1, 8'b0000_0100));
      tra_req = 1'b1; tra_data = 4'b1111;
      wait_phase(3'd2);
      tra_req = 1'b0;
      wait_phase(3'd5);
      cds_req = 1'b1; cds_data = 5'b11111;
      wait_phase(3'd6);
      cds_req = 1'b0;
      wait_phase(3'd0);
      sb_drain("offslot");
      check_value("offslot_ds", {27'd0, sec_ds, sec_dss}, {27'd0, 5'b1010_0});
      check_value("short_is", {28'd0, sec_is}, {28'd0, 4'b0110});

      // Reset asserted at the arbitration phase with HOP pending
      sb_flush();
      hop_req = 1'b1; hop_data = 10'b11_1111_1111;
      wait_phase(3'd3);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      hop_req = 1'b0;
      check_value("midrst_regs", {22'd0, sec_is, sec_iss, sec_ds, sec_dss}, 32'd0);
      check_value("midrst_acks", {29'd0, hop_ack, cds_ack, tra_ack}, 32'd0);
      check_value("midrst_phase", {29'd0, phase}, 32'd0);
      rstn = 1'b1;
      sb_drain("midrst");

      // Corner configuration: grant wraps to phase 0, decode on that cycle sees new sector
      for (int k = 0; k < 16 && c_phase != 2'd0; k++) @(negedge clk);
      check_value("c_sync", {30'd0, c_phase}, 32'd0);
      c_hop_req = 1'b1; c_hop_data = 10'b1001_1_1101_0;
      @(negedge clk);
      check_value("c_ack_ph1", {29'd0, c_hop_ack, c_cds_ack, c_tra_ack}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      check_value("c_ack_ph3", {29'd0, c_hop_ack, c_cds_ack, c_tra_ack}, 32'd0);
      @(negedge clk);
      check_value("c_ack_phase", {30'd0, c_phase}, 32'd0);
      check_value("c_ack", {29'd0, c_hop_ack, c_cds_ack, c_tra_ack}, {29'd0, 3'b100});
      check_value("c_regs", {22'd0, c_is, c_iss, c_ds, c_dss}, {22'd0, 10'b1001_1_1101_0});
      c_hop_req = 1'b0;
      @(negedge clk);
      check_value("c_ack_done", {29'd0, c_hop_ack, c_cds_ack, c_tra_ack}, 32'd0);
      check_value("c_sel", {22'd0, c_sel_y, c_sel_hi, c_sel_valid}, {22'd0, 8'b0010_0000, 1'b1, 1'b1});
      @(negedge clk);
      check_value("c_sel_hold", {22'd0, c_sel_y, c_sel_hi, c_sel_valid}, {22'd0, 8'b0010_0000, 1'b1, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sector_sched_ctrl.md
Name: sector_sched_ctrl

Overview:
- Arbitrates and sequences updates to the instruction/data sector registers: IS[3:0], ISS, DS[3:0] and DSS.
- Three requesters: HOP load, change-data-sector (CDS) and transfer (TRA).
- Once per computer cycle, drives a one-hot Y-address sector select to the Y decode.
- Replaces per-phase ad hoc gating with a single synchronous phase counter and a fixed-slot arbiter.

Parameters:
- PHASES, 8: clock ticks per computer cycle. Legal range 4..16.
- ARB_SLOT, 3: phase at which requests are sampled and arbitrated.
- DEC_SLOT, 6: phase at which the sector select is produced. Must differ from ARB_SLOT; both must be < PHASES.

Ports:
- CLK  in  1  system clock
- RSTN  in  1  synchronous reset, active-low
- HOP_REQ  in  1  HOP register load request (level)
- HOP_DATA  in  10  {IS[3:0], ISS, DS[3:0], DSS}
- CDS_REQ  in  1  change-data-sector request (level)
- CDS_DATA  in  5  {DS[3:0], DSS}
- TRA_REQ  in  1  transfer request (level)
- TRA_DATA  in  4  new IS[3:0]
- PAD_IN  in  1  instruction-fetch address mode
- A9_IN  in  1  operand address bit 9 (residual sector)
- HOP_ACK, CDS_ACK, TRA_ACK  out  1 each  one-cycle grant pulses
- IS  out  4  instruction sector register
- ISS  out  1  instruction syllable select
- DS  out  4  data sector register
- DSS  out  1  data syllable select
- PHASE  out  ceil(log2 PHASES)  current phase count
- SEL_Y  out  8  one-hot sector select (AY0..AY7)
- SEL_HI  out  1  sector bit 3 of the selected source
- SEL_VALID  out  1  SEL_Y/SEL_HI qualifier

Behaviour:
- All state is updated on the rising edge of CLK. Reset is applied when RSTN=0 at that edge.
- Reset values: PHASE=0; IS=0, ISS=0, DS=0, DSS=0; all ACKs=0; SEL_Y=0, SEL_HI=0, SEL_VALID=0.
- Reset mid-operation discards any pending grant or decode. There is no update on the reset edge.
- Phase counter:
  - Increments every cycle.
  - Wraps from PHASES-1 to 0.
- Arbitration happens only on the edge where PHASE==ARB_SLOT. Requests at any other phase are ignored. There is no queueing; a requester must hold REQ until it receives ACK.
- Priority and grants:
  - HOP_REQ has priority. On a HOP grant: load all ten bits from HOP_DATA; CDS and TRA are not granted that slot.
  - If HOP_REQ=0, TRA and CDS touch disjoint fields and may both be granted in the same slot.
  - A TRA grant loads IS only; ISS is unchanged.
  - A CDS grant loads DS and DSS only.
- Timing: register loads and ACK pulses occur on the same edge (the arbitration edge). Each ACK is high for exactly the one cycle where PHASE==(ARB_SLOT+1) mod PHASES. Data is sampled on that edge.
- Sector decode happens on the edge where PHASE==DEC_SLOT, using register values held before that edge:
  - if PAD_IN=1, src = {IS[3], IS[2:0]};
  - else if A9_IN=1, src = residual: index 7, SEL_HI=0;
  - else src = {DS[3], DS[2:0]}.
  - Outputs: SEL_Y = 1<<src[2:0]; SEL_HI = src bit 3; SEL_VALID=1.
- SEL_VALID is high for one cycle only. SEL_Y and SEL_HI hold their values until the next decode. SEL_Y is never multi-hot.
- If DEC_SLOT==(ARB_SLOT+1) mod PHASES, the decode still sees the newly loaded registers, because the load happened one edge earlier.
- REQ deasserted before the arbitration edge means no grant and no change.
- REQ held after ACK is treated as a new request at the next cycle's ARB_SLOT.

Test Plan:
- Reset check:
  - Stimulus: hold RSTN=0 for 3 cycles, then release.
  - Required: all outputs at reset values; PHASE counts 0..7 and wraps to 0 after 8 cycles.
- HOP load:
  - Stimulus: HOP_REQ=1 with HOP_DATA=10'b1011_1_0110_1, held from phase 0.
  - Required: HOP_ACK high only at PHASE=4; IS=1011, ISS=1, DS=0110, DSS=1 from the same edge.
- Concurrent grant and HOP priority:
  - Stimulus: TRA_REQ with TRA_DATA=0101 and CDS_REQ with CDS_DATA=0011_0 asserted together.
  - Required: both ACKs at PHASE=4; IS=0101, DS=0011, DSS=0, ISS unchanged.
  - Then assert HOP_REQ as well. Required: only HOP_ACK; TRA/CDS data not loaded.
- Decode select:
  - IS=0110, PAD_IN=1 -> at PHASE=7, SEL_Y=8'b0100_0000, SEL_HI=0, SEL_VALID pulse of 1 cycle.
  - PAD_IN=0, A9_IN=0, DS=1010 -> SEL_Y=8'b0000_0100, SEL_HI=1.
  - PAD_IN=0, A9_IN=1 -> SEL_Y=8'h80, SEL_HI=0.
- Off-slot and short requests:
  - Pulse CDS_REQ only at PHASE=5 -> no ACK, DS unchanged.
  - Assert RSTN=0 at PHASE=3 while HOP_REQ=1 -> no HOP_ACK; registers return to 0.
- Parameter corner:
  - Configuration: PHASES=4, ARB_SLOT=3, DEC_SLOT=0.
  - Required: ACK at PHASE=0 (wrap); the decode on that same cycle's edge reflects the newly loaded sector.
